// File: rtl/imgproc_pkg.sv
// Shared types and constants for the synthetic Bayer source and the imgproc chain.
package imgproc_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} gen_state_t;
    typedef enum logic [1:0] {PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_CONST} pat_mode_t;

    localparam int PIX_W = 12;

    // {R,G,B} per bar, left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [0:7][2:0] BAR_RGB = {3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};

endpackage

// File: rtl/bayer_pattern.sv
// Combinational test-pattern generator: picks one GRBG Bayer sample for pixel (x, y).
module bayer_pattern
    import imgproc_pkg::*;
#(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  pat_mode_t        mode,
    input  logic [XW-1:0]    x,
    input  logic [YW-1:0]    y,
    input  logic [2:0]       barIdx,
    input  logic [PIX_W-1:0] constVal,
    output logic [PIX_W-1:0] pixel
);

    logic [PIX_W-1:0] xs;
    logic [PIX_W-1:0] ys;
    logic [PIX_W-1:0] rampSum;
    logic [2:0]       rgb;
    logic             chanOn;

    // Only the low 12 bits of X and Y matter: the ramp wraps at 4096 and the checker uses bit 3.
    always_comb begin
        xs      = PIX_W'(x);
        ys      = PIX_W'(y);
        rampSum = xs + ys;
        rgb     = BAR_RGB[barIdx];
        case ({ys[0], xs[0]})
            2'b01:   chanOn = rgb[2];
            2'b10:   chanOn = rgb[0];
            default: chanOn = rgb[1];
        endcase
        pixel = '0;
        unique case (mode)
            PAT_BARS:  pixel = {PIX_W{chanOn}};
            PAT_RAMP:  pixel = rampSum;
            PAT_CHECK: pixel = {PIX_W{xs[3] ^ ys[3]}};
            PAT_CONST: pixel = constVal;
        endcase
    end

endmodule

// File: rtl/bayer_stream_gen.sv
// Synthetic sensor source: emits GRBG Bayer frames with line and frame blanking,
// standing in for the capture block in front of imgproc.
module bayer_stream_gen
    import imgproc_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iRUN,
    input  logic [1:0]  iMODE,
    input  logic [11:0] iCONST,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBUSY
);

    localparam int XW     = $clog2(H_ACTIVE);
    localparam int YW     = $clog2(V_ACTIVE);
    localparam int VB_LEN = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int BLW    = $clog2(VB_LEN);
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int BPW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0]  X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]  Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [BLW-1:0] HB_LAST  = BLW'(H_BLANK - 1);
    localparam logic [BLW-1:0] VB_LAST  = BLW'(VB_LEN - 1);
    localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

    gen_state_t       state;
    gen_state_t       nextState;
    pat_mode_t        mode;
    logic [XW-1:0]    xCnt;
    logic [YW-1:0]    yCnt;
    logic [BLW-1:0]   blankCnt;
    logic [2:0]       barIdx;
    logic [BPW-1:0]   barPix;
    logic [PIX_W-1:0] pixel;
    logic             frameEnd;
    logic             frameStart;

    always_ff @(posedge iCLK) begin
        if (iRST) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState  = state;
        frameEnd   = (state == VBLANK) && (blankCnt == VB_LAST);
        frameStart = iRUN && ((state == IDLE) || frameEnd);
        unique case (state)
            IDLE:    if (iRUN) nextState = ACTIVE;
            ACTIVE:  if (xCnt == X_LAST) nextState = HBLANK;
            HBLANK:  if (blankCnt == HB_LAST) nextState = (yCnt == Y_LAST) ? VBLANK : ACTIVE;
            VBLANK:  if (frameEnd) nextState = iRUN ? ACTIVE : IDLE;
            default: nextState = IDLE;
        endcase
    end

    bayer_pattern #(.XW(XW), .YW(YW)) uPattern (
        .mode     (mode),
        .x        (xCnt),
        .y        (yCnt),
        .barIdx   (barIdx),
        .constVal (iCONST),
        .pixel    (pixel)
    );

    // Outputs describe the position generated in the previous cycle, so every output is a plain register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
            oBUSY       <= 1'b0;
            mode        <= PAT_BARS;
            xCnt        <= '0;
            yCnt        <= '0;
            blankCnt    <= '0;
            barIdx      <= '0;
            barPix      <= '0;
        end else begin
            oBUSY   <= (state != IDLE);
            oDVAL   <= (state == ACTIVE);
            oDATA   <= (state == ACTIVE) ? pixel : '0;
            oX_Cont <= (state == ACTIVE) ? 16'(xCnt) : 16'd0;
            oY_Cont <= (state == ACTIVE || state == HBLANK) ? 16'(yCnt) : 16'd0;
            if (frameStart) mode <= pat_mode_t'(iMODE);
            if (frameEnd)   oFrame_Cont <= oFrame_Cont + 32'd1;

            unique case (state)
                IDLE: begin
                    xCnt     <= '0;
                    yCnt     <= '0;
                    blankCnt <= '0;
                    barIdx   <= '0;
                    barPix   <= '0;
                end
                ACTIVE: begin
                    if (xCnt == X_LAST) begin
                        xCnt     <= '0;
                        barIdx   <= '0;
                        barPix   <= '0;
                        blankCnt <= '0;
                    end else begin
                        xCnt <= xCnt + XW'(1);
                        // Bar index advances every BAR_W pixels without needing a divider.
                        if (barPix == BAR_LAST) begin
                            barPix <= '0;
                            barIdx <= barIdx + 3'd1;
                        end else begin
                            barPix <= barPix + BPW'(1);
                        end
                    end
                end
                HBLANK: begin
                    if (blankCnt == HB_LAST) begin
                        blankCnt <= '0;
                        yCnt     <= (yCnt == Y_LAST) ? '0 : yCnt + YW'(1);
                    end else begin
                        blankCnt <= blankCnt + BLW'(1);
                    end
                end
                VBLANK: begin
                    blankCnt <= frameEnd ? '0 : blankCnt + BLW'(1);
                end
                default: blankCnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bayer_stream_gen.sv
// Self-checking bench for bayer_stream_gen: frame-position reference model plus directed vectors and sequences.
module tb_bayer_stream_gen;

    localparam int H     = 16;
    localparam int V     = 4;
    localparam int HB    = 2;
    localparam int VB    = 1;
    localparam int LINE  = H + HB;
    localparam int FRAME = (V + VB) * LINE;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iRUN = 1'b0;
    logic [1:0]  iMODE = 2'd0;
    logic [11:0] iCONST = 12'd0;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [15:0] oX_Cont;
    logic [15:0] oY_Cont;
    logic [31:0] oFrame_Cont;
    logic        oBUSY;

    int checks = 0;
    int passes = 0;
    bit monOn = 1'b0;

    bayer_stream_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .iCLK        (clock),
        .iRST        (reset),
        .iRUN        (iRUN),
        .iMODE       (iMODE),
        .iCONST      (iCONST),
        .oDATA       (oDATA),
        .oDVAL       (oDVAL),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oFrame_Cont (oFrame_Cont),
        .oBUSY       (oBUSY)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    endtask

    task automatic failTimeout(input string name, input int bound);
        checks++;
        $display("[TB] FAIL %s: got timeout, want event within %0d cycles", name, bound);
    endtask

    task automatic applyStimulus(input logic run, input logic [1:0] mode, input logic [11:0] cval);
        iRUN   = run;
        iMODE  = mode;
        iCONST = cval;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic waitPixel(input int x, input int y, input string name);
        int n = 0;
        while (!(oDVAL && oX_Cont == 16'(x) && oY_Cont == 16'(y)) && n < 2 * FRAME) begin
            tick(1);
            n++;
        end
        if (n >= 2 * FRAME) failTimeout(name, 2 * FRAME);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (oBUSY && n < 2 * FRAME + 4) begin
            tick(1);
            n++;
        end
        checkOutput(name, oBUSY, 0);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Expected Bayer sample derived from bar colours and the GRBG phase.
    function automatic int patternRef(input int mode, input int x, input int y, input int cval);
        int  b;
        bit  hasR, hasG, hasB, on;
        case (mode)
            0: begin
                b    = x / (H / 8);
                hasG = (b < 4);
                hasR = ((b % 4) < 2);
                hasB = ((b % 2) == 0);
                if (y % 2 == 0) on = (x % 2 == 0) ? hasG : hasR;
                else            on = (x % 2 == 0) ? hasB : hasG;
                return on ? 'hFFF : 0;
            end
            1:       return (x + y) % 4096;
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 'hFFF : 0;
            default: return cval;
        endcase
    endfunction

    // Reference model: gPos is the frame position being generated, -1 when idle.
    int          gPos = -1;
    int          mMode = 0;
    logic [31:0] mFrames = '0;
    bit          expBusy, expDval;
    int          expX, expY, expData;

    always @(posedge clock) begin
        int line, col;
        if (reset) begin
            gPos = -1; mMode = 0; mFrames = '0;
            expBusy = 0; expDval = 0; expX = 0; expY = 0; expData = 0;
        end else begin
            expBusy = (gPos >= 0);
            expDval = 0; expX = 0; expY = 0; expData = 0;
            if (gPos >= 0) begin
                line = gPos / LINE;
                col  = gPos % LINE;
                if (line < V && col < H) begin
                    expDval = 1;
                    expX    = col;
                    expY    = line;
                    expData = patternRef(mMode, col, line, int'(iCONST));
                end
                if (gPos == FRAME - 1) begin
                    mFrames = mFrames + 32'd1;
                    gPos    = iRUN ? 0 : -1;
                    if (iRUN) mMode = int'(iMODE);
                end else begin
                    gPos++;
                end
            end else if (iRUN) begin
                gPos  = 0;
                mMode = int'(iMODE);
            end
        end
    end

    always @(negedge clock) begin
        if (monOn) begin
            checkOutput("mon dval", oDVAL, expDval);
            checkOutput("mon busy", oBUSY, expBusy);
            checkOutput("mon frames", oFrame_Cont, mFrames);
            if (expDval) begin
                checkOutput("mon data", oDATA, expData);
                checkOutput("mon x", oX_Cont, expX);
                checkOutput("mon y", oY_Cont, expY);
            end
        end
    end

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] cval;
        int          x;
        int          y;
        logic [11:0] expData;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int n, cyc, pix;
        vecs[0]  = '{2'd0, 12'h000, 0,  0, 12'hFFF};
        vecs[1]  = '{2'd0, 12'h000, 1,  0, 12'hFFF};
        vecs[2]  = '{2'd0, 12'h000, 2,  0, 12'hFFF};
        vecs[3]  = '{2'd0, 12'h000, 3,  0, 12'hFFF};
        vecs[4]  = '{2'd0, 12'h000, 4,  0, 12'hFFF};
        vecs[5]  = '{2'd0, 12'h000, 5,  0, 12'h000};
        vecs[6]  = '{2'd0, 12'h000, 8,  0, 12'h000};
        vecs[7]  = '{2'd0, 12'h000, 9,  0, 12'hFFF};
        vecs[8]  = '{2'd0, 12'h000, 14, 0, 12'h000};
        vecs[9]  = '{2'd0, 12'h000, 15, 0, 12'h000};
        vecs[10] = '{2'd0, 12'h000, 0,  1, 12'hFFF};
        vecs[11] = '{2'd0, 12'h000, 2,  1, 12'h000};
        vecs[12] = '{2'd1, 12'h000, 7,  0, 12'h007};
        vecs[13] = '{2'd1, 12'h000, 15, 3, 12'h012};
        vecs[14] = '{2'd2, 12'h000, 8,  0, 12'hFFF};
        vecs[15] = '{2'd2, 12'h000, 7,  3, 12'h000};
        vecs[16] = '{2'd3, 12'h5A5, 6,  2, 12'h5A5};
        vecs[17] = '{2'd2, 12'h000, 9,  1, 12'hFFF};

        // Reset values
        tick(3);
        checkOutput("reset dval", oDVAL, 0);
        checkOutput("reset busy", oBUSY, 0);
        checkOutput("reset data", oDATA, 0);
        checkOutput("reset x", oX_Cont, 0);
        checkOutput("reset y", oY_Cont, 0);
        checkOutput("reset frames", oFrame_Cont, 0);
        reset = 1'b0;
        monOn = 1'b1;

        // First-pixel latency, then three back-to-back frames in ramp mode
        applyStimulus(1'b1, 2'd1, 12'h000);
        n = 0;
        while (!oDVAL && n < 10) begin
            tick(1);
            n++;
        end
        checkOutput("first pixel latency", n, 2);
        checkOutput("first pixel x", oX_Cont, 0);
        checkOutput("first pixel y", oY_Cont, 0);
        for (int f = 1; f <= 3; f++) begin
            tick(FRAME);
            checkOutput($sformatf("frame%0d start dval", f), oDVAL, 1);
            checkOutput($sformatf("frame%0d start x", f), oX_Cont, 0);
            checkOutput($sformatf("frame%0d start y", f), oY_Cont, 0);
            checkOutput($sformatf("frame%0d count", f), oFrame_Cont, f);
        end
        applyStimulus(1'b0, 2'd1, 12'h000);
        waitIdle("continuous idle");

        // Directed pixel vectors, one frame each
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, vecs[i].mode, vecs[i].cval);
            waitPixel(vecs[i].x, vecs[i].y, $sformatf("vec%0d pixel", i));
            checkOutput($sformatf("vec%0d data", i), oDATA, vecs[i].expData);
            applyStimulus(1'b0, vecs[i].mode, vecs[i].cval);
            waitIdle($sformatf("vec%0d idle", i));
        end

        // Mode and constant change mid-frame
        applyStimulus(1'b1, 2'd3, 12'h123);
        waitPixel(0, 1, "modechg row1");
        checkOutput("modechg before", oDATA, 12'h123);
        applyStimulus(1'b1, 2'd2, 12'hABC);
        waitPixel(0, 2, "modechg row2");
        checkOutput("modechg live const", oDATA, 12'hABC);
        waitPixel(8, 0, "modechg next frame");
        checkOutput("modechg checker", oDATA, 12'hFFF);
        applyStimulus(1'b0, 2'd2, 12'hABC);
        waitIdle("modechg idle");

        // iRUN dropped on row 1: frame completes, then idle
        pulseReset();
        applyStimulus(1'b1, 2'd1, 12'h000);
        waitPixel(0, 1, "drop row1");
        applyStimulus(1'b0, 2'd1, 12'h000);
        cyc = 0;
        pix = 0;
        while (oBUSY && cyc < 2 * FRAME) begin
            tick(1);
            cyc++;
            if (oDVAL) pix++;
        end
        checkOutput("drop cycles to idle", cyc, FRAME - LINE);
        checkOutput("drop remaining pixels", pix, V * H - H - 1);
        checkOutput("drop frame count", oFrame_Cont, 1);
        pix = 0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            if (oDVAL) pix++;
        end
        checkOutput("drop no further dval", pix, 0);

        // Reset at row 2, X=5
        pulseReset();
        applyStimulus(1'b1, 2'd0, 12'h000);
        waitPixel(5, 2, "rst row2x5");
        reset = 1'b1;
        tick(1);
        checkOutput("midrst dval", oDVAL, 0);
        checkOutput("midrst busy", oBUSY, 0);
        checkOutput("midrst data", oDATA, 0);
        checkOutput("midrst x", oX_Cont, 0);
        checkOutput("midrst y", oY_Cont, 0);
        checkOutput("midrst frames", oFrame_Cont, 0);
        reset = 1'b0;
        n = 0;
        while (!oDVAL && n < 10) begin
            tick(1);
            n++;
        end
        checkOutput("restart latency", n, 2);
        checkOutput("restart x", oX_Cont, 0);
        checkOutput("restart y", oY_Cont, 0);
        applyStimulus(1'b0, 2'd0, 12'h000);
        waitIdle("restart idle");
        checkOutput("restart frames", oFrame_Cont, 1);

        // Randomized run/mode/const traffic with occasional resets
        iRUN = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 59) == 0) iRUN = ~iRUN;
            iMODE  = 2'($urandom_range(0, 3));
            iCONST = 12'($urandom);
            reset  = ($urandom_range(0, 699) == 0);
            tick(1);
        end
        reset = 1'b0;
        iRUN  = 1'b0;
        tick(1);
        waitIdle("random idle");
        tick(2);
        monOn = 1'b0;

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bayer_stream_gen.md
Name: bayer_stream_gen

Overview:
Synthetic camera-side source for the Bayer pixel stream that imgproc consumes. It produces iDATA/iDVAL/iX_Cont/iY_Cont-compatible outputs with line and frame blanking. This lets the processing chain (grayscale, row buffers, convolution) run and be verified without the sensor capture path. It sits in place of the capture block and drives imgproc directly.

Parameters:
H_ACTIVE, 640, active pixels per line (even, multiple of 8)
V_ACTIVE, 480, active lines per frame (even)
H_BLANK, 16, idle cycles after each active line (>=1)
V_BLANK, 4, blank lines after each frame, each H_ACTIVE+H_BLANK cycles (>=1)

Ports:
iCLK  in  1  clock
iRST  in  1  reset
iRUN  in  1  level: generate frames continuously while high
iMODE  in  2  pattern select, sampled at frame start
iCONST  in  12  constant pixel value for mode 3
oDATA  out  12  Bayer pixel value
oDVAL  out  1  pixel valid
oX_Cont  out  16  column of current pixel
oY_Cont  out  16  row of current pixel
oFrame_Cont  out  32  completed-frame count
oBUSY  out  1  high whenever not IDLE

Behaviour:
- One clock iCLK; reset iRST synchronous, active-high.
- Reset: state IDLE; oDATA=0, oDVAL=0, oX_Cont=0, oY_Cont=0, oFrame_Cont=0, oBUSY=0; latched mode=0.
- All outputs registered. oDATA/oX_Cont/oY_Cont are meaningful only when oDVAL=1.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE -> ACTIVE: on the first cycle iRUN=1 seen. iMODE is latched. The first pixel (X=0, Y=0, oDVAL=1) appears on the next cycle.
- ACTIVE: one pixel per cycle with oDVAL=1; X increments.
  - After X=H_ACTIVE-1 -> HBLANK.
  - During HBLANK: oDVAL=0, oX_Cont=0, blank counter runs H_BLANK cycles.
- HBLANK end:
  - If Y<V_ACTIVE-1: Y++, go to ACTIVE.
  - Else go to VBLANK; oY_Cont=0.
- VBLANK: V_BLANK*(H_ACTIVE+H_BLANK) cycles with oDVAL=0. On its last cycle oFrame_Cont increments by 1 (wraps at 2^32).
  - If iRUN=1: re-latch iMODE, go to ACTIVE.
  - Else go to IDLE.
- Frame period: V_ACTIVE*(H_ACTIVE+H_BLANK) + V_BLANK*(H_ACTIVE+H_BLANK) cycles. No gaps between frames while iRUN stays high.
- iRUN falling mid-frame: the current frame completes, including VBLANK, then the block goes to IDLE. Frames are never truncated.
- iMODE or iCONST changes mid-frame:
  - iMODE takes effect only at the next frame start.
  - iCONST is used live.
- Reset mid-frame: immediate return to reset values on the next edge. No partial-frame count.
- Bayer phase (GRBG), keyed on (Y[0],X[0]):
  - 00 = G
  - 01 = R
  - 10 = B
  - 11 = G
- Mode 0, colour bars: 8 bars, each BAR_W = H_ACTIVE/8 pixels, tracked by a bar counter (no divider).
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - The sampled component is 12'hFFF if that colour contains the Bayer channel, else 12'h000.
- Mode 1, ramp: oDATA = (X+Y) mod 4096.
- Mode 2, checker: oDATA = 12'hFFF if X[3]^Y[3], else 12'h000.
- Mode 3, constant: oDATA = iCONST.
- Counter widths: internal X/Y counters sized with $clog2; outputs zero-extended to 16 bits. Blank counter sized for V_BLANK*(H_ACTIVE+H_BLANK).

Decomposition:
- Package imgproc_pkg holds:
  - typedef enum logic [1:0] gen_state_t {IDLE, ACTIVE, HBLANK, VBLANK}
  - typedef enum logic [1:0] pat_mode_t {PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_CONST}
  - localparam PIX_W=12
  - colour-bar RGB table as a constant 8x3-bit array
- One sub-module, bayer_pattern: purely combinational. Inputs (mode, X, Y, bar index, iCONST); output 12-bit pixel. The parent registers the output.

Test Plan:
(Use H_ACTIVE=8, V_ACTIVE=4, H_BLANK=2, V_BLANK=1 unless stated.)
- Reset then iRUN=1 for one frame, mode 1:
  - First oDVAL=1 exactly 2 cycles after iRUN rises.
  - 32 valid pixels; row 0 oDATA = 0..7, row 3 = 3..10.
  - Each row followed by 2 cycles of oDVAL=0, then 10 VBLANK cycles.
  - oFrame_Cont=1 after 50 cycles from first pixel.
- iRUN held high, 3 frames:
  - Frames back-to-back, period 50 cycles each.
  - oFrame_Cont reads 1, 2, 3; X/Y sequences identical each frame.
- Mode 0, H_ACTIVE=16:
  - Row 0: X0 G=FFF, X1 R=FFF (white).
  - X2..3 yellow: G=FFF, R=FFF.
  - X4..5 cyan: G=FFF, R=000.
  - Last bar (X14..15) all 000.
  - Row 1 X0 B=FFF.
- Mode change: iMODE 3→2 and iCONST=12'hABC mid-frame.
  - Remainder of the frame outputs ABC.
  - Next frame outputs checker (with H_ACTIVE=16: X=8, Y=0 gives FFF).
- iRUN drop at row 1:
  - The frame finishes all 4 rows plus VBLANK.
  - oBUSY falls the cycle after VBLANK ends; oFrame_Cont=1; no further oDVAL.
- iRST asserted at row 2, X=5:
  - Next cycle all outputs 0, state IDLE.
  - oFrame_Cont stays 0; restart begins at X=0, Y=0.
